// File: rtl/matmul_pkg.sv
// Shared types and fixed-point helpers for the sequential matrix multiplier.
// State encoding, accumulator sizing, rounding constant and saturation limits.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Full-precision product plus enough headroom to sum N of them without overflow.
  function automatic int acc_width(input int data_width, input int n);
    return 2 * data_width + $clog2(n);
  endfunction

  // Half an output LSB, added before the right shift for round-half-up.
  function automatic longint round_const(input int fract_width);
    return longint'(1) <<< (fract_width - 1);
  endfunction

  function automatic longint sat_max(input int data_width);
    return (longint'(1) <<< (data_width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int data_width);
    return -(longint'(1) <<< (data_width - 1));
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up and saturation of one accumulator down to DATA_WIDTH.
// Defining MATMUL_RELU_EN additionally clamps negative results to zero.
module fxp_round_sat
  import matmul_pkg::*;
#(
  parameter int IN_WIDTH    = 35,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic signed [IN_WIDTH-1:0]   acc_in,
  output logic signed [DATA_WIDTH-1:0] res
);

  // One extra bit so the rounding addition can never wrap.
  localparam int EW = IN_WIDTH + 1;
  localparam logic signed [EW-1:0] RND   = EW'(round_const(FRACT_WIDTH));
  localparam logic signed [EW-1:0] MAX_V = EW'(sat_max(DATA_WIDTH));
  localparam logic signed [EW-1:0] MIN_V = EW'(sat_min(DATA_WIDTH));

  logic signed [EW-1:0]         rounded;
  logic signed [EW-1:0]         shifted;
  logic signed [DATA_WIDTH-1:0] sat;

  assign rounded = {acc_in[IN_WIDTH-1], acc_in} + RND;
  assign shifted = rounded >>> FRACT_WIDTH;

  always_comb begin
    if (shifted > MAX_V) begin
      sat = MAX_V[DATA_WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      sat = MIN_V[DATA_WIDTH-1:0];
    end else begin
      sat = shifted[DATA_WIDTH-1:0];
    end
  end

`ifdef MATMUL_RELU_EN
  assign res = sat[DATA_WIDTH-1] ? '0 : sat;
`else
  assign res = sat;
`endif

endmodule

// File: rtl/matmul_seq_fxp.sv
// Sequential fixed-point Y = A*B: P MAC lanes stepped over (row, k) for M*N cycles.
// Output rounding/saturation lives in fxp_round_sat; MATMUL_RELU_EN enables fused ReLU there.
module matmul_seq_fxp
  import matmul_pkg::*;
#(
  parameter int M           = 4,
  parameter int N           = 3,
  parameter int P           = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [M*N*DATA_WIDTH-1:0]    a,
  input  logic [N*P*DATA_WIDTH-1:0]    b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [M*P*DATA_WIDTH-1:0]    y,
  output logic                         busy
);

  localparam int DW        = DATA_WIDTH;
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, N);
  localparam int RW        = (M > 1) ? $clog2(M) : 1;
  localparam int KW        = (N > 1) ? $clog2(N) : 1;

  state_t state, state_nxt;

  logic [RW-1:0]           r_cnt;
  logic [KW-1:0]           k_cnt;
  logic [M*N*DW-1:0]       a_q;
  logic [N*P*DW-1:0]       b_q;
  logic [M*P*DW-1:0]       y_q;
  logic signed [ACC_WIDTH-1:0] acc      [P];
  logic signed [ACC_WIDTH-1:0] acc_next [P];
  logic signed [DW-1:0]    b_el     [P];
  logic signed [2*DW-1:0]  prod     [P];
  logic signed [DW-1:0]    row_res  [P];
  logic signed [DW-1:0]    a_el;
  logic                    last_k;
  logic                    last_r;

  assign last_k = (k_cnt == KW'(N - 1));
  assign last_r = (r_cnt == RW'(M - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)         state_nxt = COMPUTE;
      COMPUTE: if (last_r && last_k) state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // A[r][k] is broadcast to every lane; lane j pairs it with B[k][j].
  always_comb begin
    a_el = a_q[(int'(r_cnt) * N + int'(k_cnt)) * DW +: DW];
    for (int j = 0; j < P; j++) begin
      b_el[j] = b_q[(int'(k_cnt) * P + j) * DW +: DW];
      prod[j] = a_el * b_el[j];
      if (k_cnt == '0) begin
        acc_next[j] = ACC_WIDTH'(prod[j]);
      end else begin
        acc_next[j] = acc[j] + ACC_WIDTH'(prod[j]);
      end
    end
  end

  for (genvar g = 0; g < P; g++) begin : g_lane
    fxp_round_sat #(
      .IN_WIDTH   (ACC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .FRACT_WIDTH(FRACT_WIDTH)
    ) u_round_sat (
      .acc_in(acc_next[g]),
      .res   (row_res[g])
    );
  end

  // Rows are written back on their last k step, so y fills in row by row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      y_q   <= '0;
      r_cnt <= '0;
      k_cnt <= '0;
      for (int j = 0; j < P; j++) acc[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            r_cnt <= '0;
            k_cnt <= '0;
          end
        end
        COMPUTE: begin
          for (int j = 0; j < P; j++) acc[j] <= acc_next[j];
          if (last_k) begin
            k_cnt <= '0;
            r_cnt <= last_r ? '0 : r_cnt + 1'b1;
            for (int j = 0; j < P; j++) begin
              y_q[(int'(r_cnt) * P + j) * DW +: DW] <= row_res[j];
            end
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign y = y_q;

endmodule
